pipe_stage_hs: RTL

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble masking of control fields. It replaces the fixed-field, single-enable inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It sits between any two pipeline stages and carries a packed control vector and a packed data vector. Stalls propagate upstream through a registered ready, and branch or exception flushes kill in-flight contents.

---
 rtl/pipe_stage_hs.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: generic inter-stage pipeline register with valid/ready
// handshake, a two-entry skid buffer (main entry M plus skid entry S),
// synchronous flush and bubble masking of the control vector.
//
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN
//   defined   -> CNT_W parameter, stall_cnt port and a saturating counter of
//                output-stall cycles (cleared by rst only, not by flush).
//   undefined -> no counter and no stall_cnt port. Handshake is unchanged.
module pipe_stage_hs #(
  parameter int                CTRL_W   = 24,
  parameter int                DATA_W   = 64,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  parameter int                CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_is,
  input  logic [DATA_W-1:0] data_is,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_os,
  output logic [DATA_W-1:0] data_os
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Occupancy of the stage. M is valid in ONE and FULL, S only in FULL.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // What happens to the M/S storage on the coming edge.
  typedef enum logic [1:0] {
    M_HOLD  = 2'b00,
    M_INPUT = 2'b01,
    M_SKID  = 2'b10,
    M_CLEAR = 2'b11
  } m_op_t;

  state_t            r_state;
  state_t            w_next_state;
  m_op_t             w_m_op;
  logic              w_load_s;

  logic              r_in_ready;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;

  logic              w_m_valid;
  logic              w_accept;
  logic              w_consume;

  assign w_m_valid = (r_state != ST_EMPTY);

  // Flush kills an input arriving in the same cycle, so it never counts as
  // accepted. Consume only happens when M actually holds an entry.
  assign w_accept  = in_valid & r_in_ready & ~flush;
  assign w_consume = w_m_valid & out_ready;

  // Next-state and storage-control decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path in always_comb infers a latch.
    w_next_state = r_state;
    w_m_op       = M_HOLD;
    w_load_s     = 1'b0;

    if (flush) begin
      w_next_state = ST_EMPTY;
      w_m_op       = M_CLEAR;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_ONE;
            w_m_op       = M_INPUT;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_m_op = M_INPUT;
          end else if (w_accept) begin
            w_next_state = ST_FULL;
            w_load_s     = 1'b1;
          end else if (w_consume) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so w_accept cannot be set.
          if (w_consume) begin
            w_next_state = ST_ONE;
            w_m_op       = M_SKID;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
          w_m_op       = M_CLEAR;
        end
      endcase
    end
  end

  // State register and the registered ready derived from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
    end
  end

  // Main entry payload. Data is reset because it is visible on data_os
  // while the stage is empty; the control half is masked when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_data <= '0;
      r_m_ctrl <= CTRL_NOP;
    end else begin
      unique case (w_m_op)
        M_INPUT: begin
          r_m_ctrl <= ctrl_is;
          r_m_data <= data_is;
        end
        M_SKID: begin
          r_m_ctrl <= r_s_ctrl;
          r_m_data <= r_s_data;
        end
        M_CLEAR: begin
          r_m_ctrl <= CTRL_NOP;
          r_m_data <= '0;
        end
        default: ;
      endcase
    end
  end

  // Skid entry payload.
  always_ff @(posedge clk) begin
    // NOTE: S is storage only and is never observed unless its valid state
    // (FULL) is set, so it carries no reset; only the state is reset.
    if (w_load_s) begin
      r_s_ctrl <= ctrl_is;
      r_s_data <= data_is;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_m_valid;
  assign ctrl_os   = w_m_valid ? r_m_ctrl : CTRL_NOP;
  assign data_os   = r_m_data;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall = w_m_valid & ~out_ready;

  // Saturating output-stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
